hazard_detect: RTL and testbench

- Decode-stage hazard unit for the 4-stage pipeline (IF, ID, EX, WB), directly upstream of the execute-stage forwarding mux.
- Compares the decoding instruction's sources against destinations still in flight.
- Produces registered mux selects (rs1_hazard, rs2_hazard, store_load_hazard) that arrive together with the instruction in EX.
- Stalls IF/ID on load-use dependencies.

---
 rtl/hazard_detect.sv | 145 ++++++++++++++
 tb/tb_hazard_detect.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect.sv
// Decode-stage hazard unit: registered EX forwarding selects and load-use stall.
// Optional macro HAZARD_STATS_EN adds a saturating stall_cycles counter port.
module hazard_detect #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        rs1_hazard,
  output logic [1:0]        rs2_hazard,
  output logic              store_load_hazard
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t            state;
  logic [1:0]        cnt;
  logic              ex_v, ex_wen, ex_load;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_v, wb_wen;
  logic [REG_AW-1:0] wb_rd;
  logic              pend_v;
  logic [REG_AW-1:0] pend_rd;

  logic       ex1, ex2, wb1, wb2, pd1, pd2;
  logic       load_use, store_fwd, issue;
  logic [1:0] rs1_sel, rs2_sel;

  // x0 is hardwired to zero, so it never forwards from any slot.
  function automatic logic hit(input logic v, input logic wen,
                               input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] src);
    return v && wen && (rd == src) && (src != '0);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex1 = hit(ex_v, ex_wen, ex_rd, id_rs1);
    ex2 = hit(ex_v, ex_wen, ex_rd, id_rs2);
    wb1 = hit(wb_v, wb_wen, wb_rd, id_rs1);
    wb2 = hit(wb_v, wb_wen, wb_rd, id_rs2);
    pd1 = hit(pend_v, 1'b1, pend_rd, id_rs1);
    pd2 = hit(pend_v, 1'b1, pend_rd, id_rs2);

    load_use  = ex_load && (ex1 || (ex2 && !id_mem_write));
    store_fwd = id_mem_write && ex_load && ex2;
    stall     = !flush && ((state == S_WAIT) || (id_valid && load_use));
    issue     = id_valid && !stall && !flush;

    // A load sitting in EX never selects alu_result; that source falls through to WB.
    rs1_sel = SEL_RF;
    if (pd1)                 rs1_sel = SEL_MEM;
    else if (ex1 && !ex_load) rs1_sel = SEL_ALU;
    else if (wb1)            rs1_sel = SEL_MEM;

    rs2_sel = SEL_RF;
    if (pd2)                 rs2_sel = SEL_MEM;
    else if (ex2 && !ex_load) rs2_sel = SEL_ALU;
    else if (wb2)            rs2_sel = SEL_MEM;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_RUN;
      cnt               <= '0;
      ex_v              <= 1'b0;
      ex_wen            <= 1'b0;
      ex_load           <= 1'b0;
      ex_rd             <= '0;
      wb_v              <= 1'b0;
      wb_wen            <= 1'b0;
      wb_rd             <= '0;
      pend_v            <= 1'b0;
      pend_rd           <= '0;
      rs1_hazard        <= SEL_RF;
      rs2_hazard        <= SEL_RF;
      store_load_hazard <= 1'b0;
    end else begin
      wb_v    <= ex_v;
      wb_wen  <= ex_wen;
      wb_rd   <= ex_rd;
      ex_v    <= issue;
      ex_wen  <= id_reg_write;
      ex_load <= id_mem_read;
      ex_rd   <= id_rd;

      rs1_hazard        <= issue ? rs1_sel : SEL_RF;
      rs2_hazard        <= issue ? rs2_sel : SEL_RF;
      store_load_hazard <= issue && store_fwd;

      if (flush) begin
        state  <= S_RUN;
        cnt    <= '0;
        pend_v <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (id_valid && load_use) begin
              pend_v  <= 1'b1;
              pend_rd <= ex_rd;
              if (LOAD_LAT > 1) begin
                state <= S_WAIT;
                cnt   <= CNT_INIT;
              end
            end else begin
              pend_v <= 1'b0;
            end
          end
          S_WAIT: begin
            if (cnt == '0) state <= S_RUN;
            else           cnt   <= cnt - 2'd1;
          end
          default: state <= S_RUN;
        endcase
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               stall_cycles <= '0;
    else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
module tb_hazard_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic       flush = 1'b0;

  logic       stall1, stall3, sl1, sl3;
  logic [1:0] r1_1, r2_1, r1_3, r2_3;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc1, sc3;
`endif

  always #5 clk = ~clk;

  hazard_detect #(.LOAD_LAT(1), .REG_AW(5)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .flush(flush), .stall(stall1),
    .rs1_hazard(r1_1), .rs2_hazard(r2_1), .store_load_hazard(sl1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc1)
`endif
  );

  hazard_detect #(.LOAD_LAT(3), .REG_AW(5)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .flush(flush), .stall(stall3),
    .rs1_hazard(r1_3), .rs2_hazard(r2_3), .store_load_hazard(sl3)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc3)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, mw;
  } ins_t;

  typedef struct packed {
    logic [1:0] r1, r2;
    logic       sl;
  } exp_t;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    sel      = 1;
  string phase    = "init";
  exp_t  exp_q[$];

  logic       stall_s, sl_s;
  logic [1:0] r1_s, r2_s;
  assign stall_s = (sel == 3) ? stall3 : stall1;
  assign r1_s    = (sel == 3) ? r1_3   : r1_1;
  assign r2_s    = (sel == 3) ? r2_3   : r2_1;
  assign sl_s    = (sel == 3) ? sl3    : sl1;

  function automatic ins_t alu(input logic [4:0] rd, rs1, rs2);
    return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, rw: 1'b1, mr: 1'b0, mw: 1'b0};
  endfunction
  function automatic ins_t ld(input logic [4:0] rd, rs1);
    return '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, rw: 1'b1, mr: 1'b1, mw: 1'b0};
  endfunction
  function automatic ins_t st(input logic [4:0] rs1, rs2);
    return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b1};
  endfunction
  function automatic ins_t nop();
    return '0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic apply(input ins_t i, input logic fl);
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rd        = i.rd;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    id_mem_write = i.mw;
    flush        = fl;
  endtask

  // One pipeline cycle: comb stall checked mid-cycle, registered selects after the edge.
  task automatic cyc(input ins_t i, input logic fl, input logic e_stall,
                     input logic [1:0] e1, input logic [1:0] e2, input logic esl);
    exp_t e;
    @(negedge clk);
    apply(i, fl);
    #1;
    check("stall", 32'(stall_s), 32'(e_stall));
    exp_q.push_back('{r1: e1, r2: e2, sl: esl});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rs1_hazard", 32'(r1_s), 32'(e.r1));
    check("rs2_hazard", 32'(r2_s), 32'(e.r2));
    check("store_load_hazard", 32'(sl_s), 32'(e.sl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(nop(), 1'b0);
    rst = 1'b1;
    #1;
    check("rst_stall", 32'(stall_s), 32'd0);
    check("rst_outs", {27'd0, r1_s, r2_s, sl_s}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // ALU back-to-back forwarding
    sel = 1; phase = "alu_fwd";
    do_reset();
    cyc(alu(5, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(6, 5, 7), 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);

    // Load-use with LOAD_LAT=1, then confirm the pending match is gone
    phase = "load_use1";
    do_reset();
    cyc(ld(5, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(6, 0, 5), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    cyc(alu(6, 0, 5), 1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
    cyc(alu(7, 5, 0), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // Store data from a load in EX: no stall, memtoreg path flagged
    phase = "store_load";
    do_reset();
    cyc(ld(5, 1), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(st(8, 5), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);

    // x0 never forwards; WB match and EX-over-WB priority
    phase = "x0_wb";
    do_reset();
    cyc(alu(0, 1, 1),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(4, 0, 0),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(9, 1, 1),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(10, 4, 9), 1'b0, 1'b0, 2'b10, 2'b01, 1'b0);
    cyc(alu(11, 10, 9), 1'b0, 1'b0, 2'b01, 2'b10, 1'b0);

    // Flush coinciding with load-use wins; idle decode gives zero selects
    phase = "flush_lu";
    do_reset();
    cyc(ld(5, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(6, 0, 5), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // LOAD_LAT=3 load-use: three stall cycles then pending-load selects
    sel = 3; phase = "load_use3";
    do_reset();
    cyc(ld(9, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
`ifdef HAZARD_STATS_EN
    check("stall_cycles", sc3, 32'd3);
`endif

    // Flush during the second stall cycle aborts the wait
    phase = "flush_wait";
    do_reset();
    cyc(ld(9, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    // Asynchronous reset in the middle of WAIT
    phase = "rst_wait";
    do_reset();
    cyc(ld(9, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    cyc(alu(1, 9, 9), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    check("wait_stall", 32'(stall_s), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_stall", 32'(stall_s), 32'd0);
    check("async_outs", {27'd0, r1_s, r2_s, sl_s}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("async_stall_cycles", sc3, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cyc(alu(1, 9, 9), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
